// File: rtl/display_pkg.sv
// Shared constants and types for the 3-digit BCD seven-segment display.
// Segment patterns are active-low: bit 0 = segment a ... bit 6 = segment g.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;

    // Packed BCD word as presented on BCDCODE.
    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd3_t;

    // Pattern for a nibble; anything outside 0-9 shows E.
    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_E;
        endcase
    endfunction

endpackage

// File: rtl/display_if.sv
// Load/data/segment bundle for the display block.
// master drives the BCD value and strobe; slave (the display) drives the segments.
interface display_if;

    logic        load;
    logic [11:0] BCDCODE;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;

    modport master (
        output load, BCDCODE,
        input  HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  load, BCDCODE,
        output HEX0, HEX1, HEX2, HEX3
    );

endinterface

// File: rtl/seg7_decoder.sv
// Nibble-to-segment decoder with a blank request. An invalid nibble (10-15)
// always shows E, even when blanking is requested, so bad data is never hidden.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Pure lookup: invalid beats blank, blank beats the digit pattern.
    // NOTE: every path through this always_comb assigns seg_o, so no latch is inferred.
    always_comb begin
        if (nibble_i > 4'd9) begin
            seg_o = SEG_E;
        end else if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = seg_of_digit(nibble_i);
        end
    end

endmodule

// File: rtl/display.sv
// 3-digit BCD display driver: captures BCDCODE on load and presents the
// decoded, registered segments on the same edge; HEX3 is a permanent blank.
// Optional feature: define DISPLAY_LZB_EN for leading-zero blanking.
module display
    import display_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    display_if.slave bus
);

    bcd3_t      bcd_q;
    bcd3_t      bcd_d;
    logic       blank_hund;
    logic       blank_tens;
    logic [6:0] hex0_d, hex1_d, hex2_d;
    logic [6:0] hex0_q, hex1_q, hex2_q;

    // Value the register will hold after this edge; the decoders look at it so
    // the outputs reflect a new capture on the very edge that captures it.
    always_comb begin
        bcd_d = bus.load ? bcd3_t'(bus.BCDCODE) : bcd_q;
    end

`ifdef DISPLAY_LZB_EN
    // Leading zeros are blanked; units is always shown.
    assign blank_hund = (bcd_d.hundreds == 4'd0);
    assign blank_tens = (bcd_d.hundreds == 4'd0) && (bcd_d.tens == 4'd0);
    localparam logic [6:0] LEAD_RST = SEG_BLANK;
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
    localparam logic [6:0] LEAD_RST = SEG_0;
`endif

    seg7_decoder u_dec_units (
        .nibble_i (bcd_d.units),
        .blank_i  (1'b0),
        .seg_o    (hex0_d)
    );

    seg7_decoder u_dec_tens (
        .nibble_i (bcd_d.tens),
        .blank_i  (blank_tens),
        .seg_o    (hex1_d)
    );

    seg7_decoder u_dec_hund (
        .nibble_i (bcd_d.hundreds),
        .blank_i  (blank_hund),
        .seg_o    (hex2_d)
    );

    // Capture register and output registers; reset shows the decoded value 000.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcd_q  <= '0;
            hex0_q <= SEG_0;
            hex1_q <= LEAD_RST;
            hex2_q <= LEAD_RST;
        end else begin
            bcd_q  <= bcd_d;
            hex0_q <= hex0_d;
            hex1_q <= hex1_d;
            hex2_q <= hex2_d;
        end
    end

    assign bus.HEX0 = hex0_q;
    assign bus.HEX1 = hex1_q;
    assign bus.HEX2 = hex2_q;
    assign bus.HEX3 = SEG_BLANK;

endmodule

// File: tb/tb_display.sv
// Self-checking bench for display: a behavioural model (captured value plus a
// digit table) is compared against the outputs every falling edge, with
// literal expectations for the hand-worked scenarios.
module tb_display;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic chk_en = 1'b0;
    logic [11:0] model_val = '0;
    int n_vec = 0;
    int n_err = 0;

    display_if bus ();

    display dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Expected pattern for a digit position (0=units .. 3=thousands) of a value.
    function automatic logic [6:0] exp_seg(input int pos, input logic [11:0] v);
        logic [6:0] tbl [10];
        int n;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (pos == 3) return 7'h7F;
        n = int'((v >> (4 * pos)) & 12'hF);
        if (n > 9) return 7'h06;
`ifdef DISPLAY_LZB_EN
        if (pos == 2 && n == 0) return 7'h7F;
        if (pos == 1 && v[11:4] == 8'h00) return 7'h7F;
`endif
        return tbl[n];
    endfunction

    function automatic logic [11:0] to_bcd(input int i);
        return {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (model %h) at %0t", name, act, exp, model_val, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_hex0"}, bus.HEX0, exp_seg(0, model_val));
        check({tag, "_hex1"}, bus.HEX1, exp_seg(1, model_val));
        check({tag, "_hex2"}, bus.HEX2, exp_seg(2, model_val));
        check({tag, "_hex3"}, bus.HEX3, exp_seg(3, model_val));
    endtask

    // Drive inputs, take one rising edge, advance the model, move off the edge.
    task automatic step(input logic l, input logic [11:0] code);
        bus.load    = l;
        bus.BCDCODE = code;
        @(posedge clock);
        if (!reset && l) model_val = code;
        #1;
    endtask

    // Compare process: outputs are meaningful every cycle once reset has been seen.
    always @(negedge clock) begin
        if (chk_en) compare_all("cyc");
    end

    initial begin
        bus.load    = 1'b0;
        bus.BCDCODE = '0;

        // Asynchronous reset with no clock edge yet.
        #2;
        reset     = 1'b1;
        model_val = '0;
        #1;
        check("rst_hex0_lit", bus.HEX0, 7'h40);
        check("rst_hex3_lit", bus.HEX3, 7'h7F);
`ifdef DISPLAY_LZB_EN
        check("rst_hex1_lit", bus.HEX1, 7'h7F);
        check("rst_hex2_lit", bus.HEX2, 7'h7F);
`else
        check("rst_hex1_lit", bus.HEX1, 7'h40);
        check("rst_hex2_lit", bus.HEX2, 7'h40);
`endif
        chk_en = 1'b1;
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        reset = 1'b0;

        // Load 255, then hold with load low.
        step(1'b1, 12'h255);
        check("ld255_hex2_lit", bus.HEX2, 7'h24);
        check("ld255_hex1_lit", bus.HEX1, 7'h12);
        check("ld255_hex0_lit", bus.HEX0, 7'h12);
        check("ld255_hex3_lit", bus.HEX3, 7'h7F);
        step(1'b0, 12'h000);
        step(1'b0, 12'h000);
        check("hold_hex2_lit", bus.HEX2, 7'h24);
        check("hold_hex1_lit", bus.HEX1, 7'h12);
        check("hold_hex0_lit", bus.HEX0, 7'h12);

        // Invalid tens digit.
        step(1'b1, 12'h1A3);
        check("inv_hex2_lit", bus.HEX2, 7'h79);
        check("inv_hex1_lit", bus.HEX1, 7'h06);
        check("inv_hex0_lit", bus.HEX0, 7'h30);

        // Leading zeros.
        step(1'b1, 12'h007);
        check("lz007_hex0_lit", bus.HEX0, 7'h78);
`ifdef DISPLAY_LZB_EN
        check("lz007_hex1_lit", bus.HEX1, 7'h7F);
        check("lz007_hex2_lit", bus.HEX2, 7'h7F);
`else
        check("lz007_hex1_lit", bus.HEX1, 7'h40);
        check("lz007_hex2_lit", bus.HEX2, 7'h40);
`endif
        step(1'b1, 12'h050);
        check("lz050_hex1_lit", bus.HEX1, 7'h12);
        check("lz050_hex0_lit", bus.HEX0, 7'h40);
`ifdef DISPLAY_LZB_EN
        check("lz050_hex2_lit", bus.HEX2, 7'h7F);
`else
        check("lz050_hex2_lit", bus.HEX2, 7'h40);
`endif
        step(1'b1, 12'h00C);
        check("lz00c_hex0_lit", bus.HEX0, 7'h06);

        // Reset wins over a simultaneous load.
        reset     = 1'b1;
        model_val = '0;
        #1;
        compare_all("midrst");
        step(1'b1, 12'h999);
        check("prio_hex0_lit", bus.HEX0, 7'h40);
        reset = 1'b0;
        step(1'b1, 12'h999);
        check("prio999_hex2_lit", bus.HEX2, 7'h10);
        check("prio999_hex1_lit", bus.HEX1, 7'h10);
        check("prio999_hex0_lit", bus.HEX0, 7'h10);

        // Sweep 0..255 as BCD; the compare process checks every edge.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, to_bcd(i));
        end

        // Randomized loads, holds, invalid nibbles and mid-run resets.
        for (int k = 0; k < 400; k++) begin
            logic [11:0] code;
            if ($urandom_range(0, 9) < 7) code = to_bcd(int'($urandom_range(0, 999)));
            else                          code = 12'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                reset     = 1'b1;
                model_val = '0;
                #1;
                compare_all("rndrst");
                step(1'($urandom_range(0, 1)), code);
                reset = 1'b0;
            end else begin
                step(1'($urandom_range(0, 1)), code);
            end
        end

        step(1'b0, 12'h000);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
